score_tracker: RTL and testbench

- Upstream producer of the 7-bit score value consumed by the two-digit seven-segment driver.
- Counts points during a game, saturates at MAX_SCORE, and keeps a session high score.
- After game over, alternates the displayed value between the last score and the high score so one display pair shows both.
- Sits between game logic, which emits single-cycle event pulses, and the score display driver.

---
 rtl/score_tracker_pkg.sv | 15 +
 rtl/score_tracker_saturating_counter.sv | 30 +++
 rtl/score_tracker.sv | 95 +++++++++
 tb/tb_score_tracker.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/score_tracker_pkg.sv
// Shared constants and state encoding for the score tracker and its helpers.
package score_tracker_pkg;

    localparam int SCORE_W   = 7;
    localparam int MAX_SCORE = 99;
    localparam int ALT_TICKS = 25_000_000;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PLAYING    = 2'd1,
        SHOW_SCORE = 2'd2,
        SHOW_HIGH  = 2'd3
    } state_t;

endpackage

// File: rtl/score_tracker_saturating_counter.sv
// Up-counter that sticks at CEILING; clear beats increment.
module saturating_counter #(
    parameter int WIDTH   = 7,
    parameter int CEILING = 99
) (
    input  logic             i_Clk,
    input  logic             i_Reset,
    input  logic             i_Clear,
    input  logic             i_Inc,
    output logic [WIDTH-1:0] o_Count,
    output logic [WIDTH-1:0] o_Next_Count
);

    // The ceiling compare happens before the add so the count can never wrap.
    always_comb begin
        o_Next_Count = o_Count;
        if (i_Clear)
            o_Next_Count = '0;
        else if (i_Inc && (o_Count < WIDTH'(CEILING)))
            o_Next_Count = o_Count + 1'b1;
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset)
            o_Count <= '0;
        else
            o_Count <= o_Next_Count;
    end

endmodule

// File: rtl/score_tracker.sv
// Game score tracker: saturating score, session high score, and a game-over
// display that alternates between the last score and the high score.
module score_tracker #(
    parameter int MAX_SCORE = score_tracker_pkg::MAX_SCORE,
    parameter int ALT_TICKS = score_tracker_pkg::ALT_TICKS
) (
    input  logic                                i_Clk,
    input  logic                                i_Reset,
    input  logic                                i_Game_Start,
    input  logic                                i_Point,
    input  logic                                i_Game_Over,
    output logic [score_tracker_pkg::SCORE_W-1:0] o_Display_Score,
    output logic [score_tracker_pkg::SCORE_W-1:0] o_Score,
    output logic [score_tracker_pkg::SCORE_W-1:0] o_High_Score,
    output logic                                o_New_High,
    output logic                                o_Showing_High
);

    import score_tracker_pkg::*;

    localparam int ALT_W = (ALT_TICKS > 1) ? $clog2(ALT_TICKS) : 1;

    state_t             state;
    logic [ALT_W-1:0]   alt_count;
    logic [SCORE_W-1:0] score_next;
    logic               score_inc;
    logic               alt_done;
    logic               display_high;

    assign score_inc    = (state == PLAYING) && i_Point && !i_Game_Start;
    assign alt_done     = (alt_count == ALT_W'(ALT_TICKS - 1));
    // A start request pulls the display back to the score in the same cycle it leaves SHOW_HIGH.
    assign display_high = (state == SHOW_HIGH) && !i_Game_Start;

    saturating_counter #(
        .WIDTH   (SCORE_W),
        .CEILING (MAX_SCORE)
    ) u_score (
        .i_Clk        (i_Clk),
        .i_Reset      (i_Reset),
        .i_Clear      (i_Game_Start),
        .i_Inc        (score_inc),
        .o_Count      (o_Score),
        .o_Next_Count (score_next)
    );

    // score_next already includes a same-cycle point, so the high-score compare sees it.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state           <= IDLE;
            alt_count       <= '0;
            o_High_Score    <= '0;
            o_Display_Score <= '0;
            o_New_High      <= 1'b0;
            o_Showing_High  <= 1'b0;
        end else begin
            o_New_High      <= 1'b0;
            o_Display_Score <= display_high ? o_High_Score : o_Score;
            o_Showing_High  <= display_high;
            case (state)
                IDLE: begin
                    alt_count <= '0;
                    if (i_Game_Start)
                        state <= PLAYING;
                end
                PLAYING: begin
                    alt_count <= '0;
                    if (!i_Game_Start && i_Game_Over) begin
                        state <= SHOW_SCORE;
                        if (score_next > o_High_Score) begin
                            o_High_Score <= score_next;
                            o_New_High   <= 1'b1;
                        end
                    end
                end
                SHOW_SCORE, SHOW_HIGH: begin
                    if (i_Game_Start) begin
                        state     <= PLAYING;
                        alt_count <= '0;
                    end else if (alt_done) begin
                        state     <= (state == SHOW_SCORE) ? SHOW_HIGH : SHOW_SCORE;
                        alt_count <= '0;
                    end else begin
                        alt_count <= alt_count + 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    alt_count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_score_tracker.sv
// Self-checking bench: directed game scenarios plus random pulses, every cycle
// compared against a behavioural game model.
module tb_score_tracker;

    localparam int MAX_SC = 99;
    localparam int ALT    = 4;

    logic       i_Clk = 1'b0;
    logic       i_Reset = 1'b0;
    logic       i_Game_Start = 1'b0;
    logic       i_Point = 1'b0;
    logic       i_Game_Over = 1'b0;
    logic [6:0] o_Display_Score;
    logic [6:0] o_Score;
    logic [6:0] o_High_Score;
    logic       o_New_High;
    logic       o_Showing_High;

    int checks = 0;
    int failures = 0;

    // Model: phase 0 idle, 1 playing, 2 showing last score, 3 showing high score.
    int m_phase = 0;
    int m_score = 0;
    int m_high = 0;
    int m_ticks = 0;
    int m_disp = 0;
    int m_showing = 0;
    int m_new_high = 0;

    score_tracker #(
        .MAX_SCORE (MAX_SC),
        .ALT_TICKS (ALT)
    ) dut (
        .i_Clk           (i_Clk),
        .i_Reset         (i_Reset),
        .i_Game_Start    (i_Game_Start),
        .i_Point         (i_Point),
        .i_Game_Over     (i_Game_Over),
        .o_Display_Score (o_Display_Score),
        .o_Score         (o_Score),
        .o_High_Score    (o_High_Score),
        .o_New_High      (o_New_High),
        .o_Showing_High  (o_Showing_High)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic modelStep(input bit rst, input bit start, input bit point, input bit over);
        if (rst) begin
            m_phase = 0; m_score = 0; m_high = 0; m_ticks = 0;
            m_disp = 0; m_showing = 0; m_new_high = 0;
            return;
        end
        m_showing  = (m_phase == 3 && !start) ? 1 : 0;
        m_disp     = m_showing ? m_high : m_score;
        m_new_high = 0;
        if (start) begin
            m_phase = 1; m_score = 0; m_ticks = 0;
        end else if (m_phase == 1) begin
            if (point && m_score < MAX_SC) m_score = m_score + 1;
            if (over) begin
                m_phase = 2; m_ticks = 0;
                if (m_score > m_high) begin
                    m_high = m_score;
                    m_new_high = 1;
                end
            end
        end else if (m_phase >= 2) begin
            m_ticks = m_ticks + 1;
            if (m_ticks == ALT) begin
                m_ticks = 0;
                m_phase = (m_phase == 2) ? 3 : 2;
            end
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit start, input bit point, input bit over);
        @(negedge i_Clk);
        i_Reset = rst; i_Game_Start = start; i_Point = point; i_Game_Over = over;
        @(posedge i_Clk);
        modelStep(rst, start, point, over);
        #1;
        checkOutput("score",    int'(o_Score),         m_score);
        checkOutput("high",     int'(o_High_Score),    m_high);
        checkOutput("new_high", int'(o_New_High),      m_new_high);
        checkOutput("display",  int'(o_Display_Score), m_disp);
        checkOutput("showing",  int'(o_Showing_High),  m_showing);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0);
    endtask

    task automatic playGame(input int points);
        applyStimulus(0, 1, 0, 0);
        for (int i = 0; i < points; i++) begin
            applyStimulus(0, 0, 1, 0);
            applyStimulus(0, 0, 0, 0);
        end
        applyStimulus(0, 0, 0, 1);
    endtask

    initial begin
        $display("[TB] score_tracker bench start");
        applyStimulus(1, 0, 0, 0);
        checkOutput("reset_score", int'(o_Score), 0);

        // Three spaced points, display follows two cycles after the last pulse.
        applyStimulus(0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 1, 0);
            applyStimulus(0, 0, 0, 0);
        end
        checkOutput("plan_score3", int'(o_Score), 3);
        checkOutput("plan_disp3", int'(o_Display_Score), 3);

        // Saturation at the ceiling.
        for (int i = 0; i < 105; i++) applyStimulus(0, 0, 1, 0);
        checkOutput("plan_sat", int'(o_Score), MAX_SC);
        applyStimulus(1, 0, 0, 0);

        // Games A/B/C: new high, tie, lower.
        playGame(12);
        checkOutput("plan_high12", int'(o_High_Score), 12);
        playGame(12);
        checkOutput("plan_tie_nopulse", int'(o_New_High), 0);
        playGame(5);
        checkOutput("plan_keep12", int'(o_High_Score), 12);

        // Alternation with score 7 against high 12.
        playGame(7);
        idleCycles(3 * ALT);
        applyStimulus(0, 1, 0, 0);

        // Point and game over together at a tied 40.
        playGame(40);
        applyStimulus(0, 1, 0, 0);
        for (int i = 0; i < 40; i++) applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 1, 1);
        checkOutput("plan_41", int'(o_High_Score), 41);
        checkOutput("plan_41_pulse", int'(o_New_High), 1);

        // Start collides with game over and with a point.
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 1, 0, 1);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 1, 1, 0);

        // Reset during SHOW_HIGH, then an ignored point in idle.
        applyStimulus(1, 0, 0, 0);
        playGame(30);
        idleCycles(ALT + 1);
        checkOutput("plan_in_show_high", int'(o_Showing_High), 1);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("plan_idle_ignore", int'(o_Score), 0);

        // Random pulse traffic.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 499) == 0),
                          ($urandom_range(0, 99) < 3),
                          ($urandom_range(0, 99) < 45),
                          ($urandom_range(0, 99) < 4));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
